ysyx_24100005_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single `npcmem` data path between the instruction-fetch requester (port 0) and the load/store requester (port 1) of the ysyx_24100005 core. It accepts one request at a time with round-robin arbitration and forwards it to the memory port. It waits for the memory response and returns it to the winning requester. Only then does it accept the next request. It sits between the IFU/LSU and the DPI-backed memory wrapper.

---
 rtl/ysyx_24100005_mem_arbiter_if.sv | 53 +++++
 rtl/ysyx_24100005_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_ysyx_24100005_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24100005_mem_arbiter_if.sv
// Bus bundle between the IFU/LSU requesters, the memory arbiter and the npcmem wrapper.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface ysyx_24100005_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              s0_req_valid;
    logic              s0_req_ready;
    logic [ADDR_W-1:0] s0_addr;
    logic              s0_wen;
    logic [DATA_W-1:0] s0_wdata;
    logic [7:0]        s0_wmask;
    logic              s0_resp_valid;
    logic              s0_resp_ready;
    logic [DATA_W-1:0] s0_rdata;

    logic              s1_req_valid;
    logic              s1_req_ready;
    logic [ADDR_W-1:0] s1_addr;
    logic              s1_wen;
    logic [DATA_W-1:0] s1_wdata;
    logic [7:0]        s1_wmask;
    logic              s1_resp_valid;
    logic              s1_resp_ready;
    logic [DATA_W-1:0] s1_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [7:0]        mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  s0_req_valid, s0_addr, s0_wen, s0_wdata, s0_wmask, s0_resp_ready,
        output s0_req_ready, s0_resp_valid, s0_rdata,
        input  s1_req_valid, s1_addr, s1_wen, s1_wdata, s1_wmask, s1_resp_ready,
        output s1_req_ready, s1_resp_valid, s1_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport master (
        output s0_req_valid, s0_addr, s0_wen, s0_wdata, s0_wmask, s0_resp_ready,
        input  s0_req_ready, s0_resp_valid, s0_rdata,
        output s1_req_valid, s1_addr, s1_wen, s1_wdata, s1_wmask, s1_resp_ready,
        input  s1_req_ready, s1_resp_valid, s1_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Round-robin arbiter sharing the npcmem port between instruction fetch (port 0) and load/store (port 1).
// One transaction is in flight at a time: accept, issue, wait for the memory strobe, hand back the response.
module ysyx_24100005_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_24100005_mem_arbiter_if.slave bus,
    output logic                   err
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_n;

    logic              last;
    logic              cur;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wmask_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic grant0;
    logic grant1;
    logic resp_taken;

    // A tie goes to the port that was not served most recently.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            grant0 = bus.s0_req_valid && (!bus.s1_req_valid || last);
            grant1 = bus.s1_req_valid && (!bus.s0_req_valid || !last);
        end
    end

    assign resp_taken = (state == RESP) && (cur ? bus.s1_resp_ready : bus.s0_resp_ready);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (grant0 || grant1)    state_n = ISSUE;
            ISSUE:   if (bus.mem_req_ready)   state_n = WAIT;
            WAIT:    if (bus.mem_resp_valid)  state_n = RESP;
            RESP:    if (resp_taken)          state_n = IDLE;
            default:                          state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Request fields are captured once at accept so the memory side sees them stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (grant0 || grant1) begin
            cur     <= grant1;
            addr_q  <= grant1 ? bus.s1_addr  : bus.s0_addr;
            wen_q   <= grant1 ? bus.s1_wen   : bus.s0_wen;
            wdata_q <= grant1 ? bus.s1_wdata : bus.s0_wdata;
            wmask_q <= grant1 ? bus.s1_wmask : bus.s0_wmask;
        end
    end

    // Writes return zero so a requester never sees stale bus data on a store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (state == WAIT && bus.mem_resp_valid) begin
            rdata_q <= wen_q ? '0 : bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (resp_taken) begin
            last <= cur;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.mem_resp_valid && state != WAIT) begin
            err_q <= 1'b1;
        end
    end

    assign bus.s0_req_ready  = grant0;
    assign bus.s1_req_ready  = grant1;
    assign bus.s0_resp_valid = (state == RESP) && !cur;
    assign bus.s1_resp_valid = (state == RESP) && cur;
    assign bus.s0_rdata      = rdata_q;
    assign bus.s1_rdata      = rdata_q;

    assign bus.mem_req_valid = (state == ISSUE);
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;

    assign err = err_q;
endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Scoreboard bench for the two-port memory arbiter: requesters and a memory responder are driven here,
// expected grants, memory requests and responses are queued at drive time and matched by a monitor.
module tb_ysyx_24100005_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err;

    always #5 clk = ~clk;

    ysyx_24100005_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ysyx_24100005_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .err (err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [7:0]  wmask;
    } mem_txn_t;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
    } resp_t;

    logic     grant_q[$];
    mem_txn_t mem_q[$];
    resp_t    resp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int grants_seen = 0;
    bit mem_auto = 1'b1;
    int stall_cycles = 0;
    bit s0_activity = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] memModel(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic mem_txn_t mkTxn(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [7:0] m);
        mem_txn_t t;
        t.addr = a; t.wen = w; t.wdata = d; t.wmask = m;
        return t;
    endfunction

    function automatic resp_t mkResp(input logic p, input logic [31:0] d);
        resp_t r;
        r.port = p; r.rdata = d;
        return r;
    endfunction

    task automatic setReq(input bit port, input logic v, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [7:0] m);
        if (port) begin
            bus.s1_req_valid = v; bus.s1_addr = a; bus.s1_wen = w; bus.s1_wdata = d; bus.s1_wmask = m;
        end else begin
            bus.s0_req_valid = v; bus.s0_addr = a; bus.s0_wen = w; bus.s0_wdata = d; bus.s0_wmask = m;
        end
    endtask

    // Queue all expectations for one request, raise it, and drop it the cycle after it is granted.
    task automatic applyStimulus(input bit port, input logic [31:0] a, input logic w, input logic [31:0] d,
                                 input logic [7:0] m, input bit expect_resp, output int accept_cyc);
        int n;
        @(negedge clk);
        setReq(port, 1'b1, a, w, d, m);
        grant_q.push_back(port);
        mem_q.push_back(mkTxn(a, w, d, m));
        if (expect_resp) resp_q.push_back(mkResp(port, w ? 32'h0 : memModel(a)));
        #1;
        n = 0;
        while (!(port ? bus.s1_req_ready : bus.s0_req_ready) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 50) checkOutput("grant timeout", 64'(n), 64'(0));
        accept_cyc = cyc;
        @(negedge clk);
        setReq(port, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((grant_q.size() + mem_q.size() + resp_q.size()) != 0 && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) checkOutput("drain timeout", 64'(grant_q.size() + mem_q.size() + resp_q.size()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    // Monitor: matches grants, memory handshakes and response handshakes against the queues.
    initial begin
        logic     p;
        mem_txn_t m;
        resp_t    r;
        forever begin
            @(negedge clk); #2;
            if (!rst) begin
                if (bus.s0_req_ready || bus.s0_resp_valid) s0_activity = 1'b1;
                if (bus.s0_req_ready || bus.s1_req_ready) begin
                    grants_seen++;
                    if (grant_q.size() == 0) begin
                        checkOutput("unexpected grant", 64'({bus.s1_req_ready, bus.s0_req_ready}), 64'(0));
                    end else begin
                        p = grant_q.pop_front();
                        checkOutput("grant port", 64'({bus.s1_req_ready, bus.s0_req_ready}), p ? 64'd2 : 64'd1);
                    end
                end
                if (bus.mem_req_valid && bus.mem_req_ready) begin
                    if (mem_q.size() == 0) begin
                        checkOutput("unexpected mem req", 64'(1), 64'(0));
                    end else begin
                        m = mem_q.pop_front();
                        checkOutput("mem_addr", 64'(bus.mem_addr), 64'(m.addr));
                        checkOutput("mem_wen/wmask", 64'({bus.mem_wen, bus.mem_wmask}), 64'({m.wen, m.wmask}));
                        checkOutput("mem_wdata", 64'(bus.mem_wdata), 64'(m.wdata));
                    end
                end
                if ((bus.s0_resp_valid && bus.s0_resp_ready) || (bus.s1_resp_valid && bus.s1_resp_ready)) begin
                    if (resp_q.size() == 0) begin
                        checkOutput("unexpected resp", 64'({bus.s1_resp_valid, bus.s0_resp_valid}), 64'(0));
                    end else begin
                        r = resp_q.pop_front();
                        checkOutput("resp port", 64'({bus.s1_resp_valid, bus.s0_resp_valid}), r.port ? 64'd2 : 64'd1);
                        checkOutput("resp rdata", 64'(r.port ? bus.s1_rdata : bus.s0_rdata), 64'(r.rdata));
                    end
                end
            end
        end
    end

    // Memory responder: optional request stall, accept, then a one-cycle response strobe.
    initial begin
        logic [31:0] a;
        logic        w;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst && mem_auto && bus.mem_req_valid) begin
                repeat (stall_cycles) @(negedge clk);
                a = bus.mem_addr;
                w = bus.mem_wen;
                bus.mem_req_ready = 1'b1;
                @(negedge clk);
                bus.mem_req_ready  = 1'b0;
                bus.mem_rdata      = w ? 32'hBAD0_BAD0 : memModel(a);
                bus.mem_resp_valid = 1'b1;
                @(negedge clk);
                bus.mem_resp_valid = 1'b0;
                bus.mem_rdata      = 32'h0;
            end
        end
    end

    initial begin
        int acc;
        int n;
        int target;
        bit seen;

        setReq(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
        setReq(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
        bus.s0_resp_ready = 1'b1;
        bus.s1_resp_ready = 1'b1;

        #7 rst = 1'b1;
        #1;
        checkOutput("reset err", 64'(err), 64'(0));
        checkOutput("reset req_ready", 64'({bus.s1_req_ready, bus.s0_req_ready}), 64'(0));
        checkOutput("reset resp_valid", 64'({bus.s1_resp_valid, bus.s0_resp_valid}), 64'(0));
        checkOutput("reset mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
        checkOutput("reset mem_addr", 64'(bus.mem_addr), 64'(0));
        checkOutput("reset mem_wen/wmask", 64'({bus.mem_wen, bus.mem_wmask}), 64'(0));
        checkOutput("reset mem_wdata", 64'(bus.mem_wdata), 64'(0));
        checkOutput("reset rdata", 64'({bus.s1_rdata, bus.s0_rdata}), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] single s0 read");
        applyStimulus(1'b0, 32'h8000_0000, 1'b0, 32'h0, 8'h0, 1'b1, acc);
        #1;
        n = 0;
        while (!bus.s0_resp_valid && n < 20) begin
            @(negedge clk); #1; n++;
        end
        checkOutput("read latency", 64'(cyc - acc), 64'(3));
        checkOutput("s0_rdata first read", 64'(bus.s0_rdata), 64'h0000_0413);
        waitDrain();

        $display("[TB] s1 only, repeated");
        s0_activity = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h8000_0100 + 32'(i * 4), 1'b0, 32'h0, 8'h0, 1'b1, acc);
            waitDrain();
        end
        checkOutput("s0 quiet during s1-only", 64'(s0_activity), 64'(0));

        $display("[TB] simultaneous requests");
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                grant_q.push_back(1'b0);
                mem_q.push_back(mkTxn(32'h8000_0000, 1'b0, 32'h0, 8'h0));
                resp_q.push_back(mkResp(1'b0, 32'h0000_0413));
            end else begin
                grant_q.push_back(1'b1);
                mem_q.push_back(mkTxn(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F));
                resp_q.push_back(mkResp(1'b1, 32'h0));
            end
        end
        target = grants_seen + 4;
        @(negedge clk);
        setReq(1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 8'h0);
        setReq(1'b1, 1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F);
        n = 0;
        do begin
            @(negedge clk); #3; n++;
        end while (grants_seen < target && n < 100);
        if (n >= 100) checkOutput("alternating grant timeout", 64'(grants_seen), 64'(target));
        @(negedge clk);
        setReq(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
        setReq(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
        waitDrain();

        $display("[TB] backpressure");
        stall_cycles = 5;
        bus.s0_resp_ready = 1'b0;
        applyStimulus(1'b0, 32'h8000_0040, 1'b0, 32'h0, 8'h0, 1'b1, acc);
        setReq(1'b1, 1'b1, 32'h8000_0044, 1'b0, 32'h0, 8'h0);
        grant_q.push_back(1'b1);
        mem_q.push_back(mkTxn(32'h8000_0044, 1'b0, 32'h0, 8'h0));
        resp_q.push_back(mkResp(1'b1, memModel(32'h8000_0044)));
        target = grants_seen + 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("stall mem_req_valid", 64'(bus.mem_req_valid), 64'(1));
            checkOutput("stall mem_addr", 64'(bus.mem_addr), 64'h8000_0040);
            checkOutput("stall no second grant", 64'(bus.s1_req_ready), 64'(0));
            @(negedge clk);
        end
        stall_cycles = 0;
        #1;
        n = 0;
        while (!bus.s0_resp_valid && n < 20) begin
            @(negedge clk); #1; n++;
        end
        for (int i = 0; i < 3; i++) begin
            checkOutput("held s0_resp_valid", 64'(bus.s0_resp_valid), 64'(1));
            checkOutput("held s0_rdata", 64'(bus.s0_rdata), 64'(memModel(32'h8000_0040)));
            checkOutput("held no second grant", 64'(bus.s1_req_ready), 64'(0));
            @(negedge clk); #1;
        end
        bus.s0_resp_ready = 1'b1;
        n = 0;
        while (grants_seen < target && n < 50) begin
            @(negedge clk); #3; n++;
        end
        if (n >= 50) checkOutput("s1 grant after backpressure", 64'(grants_seen), 64'(target));
        @(negedge clk);
        setReq(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
        waitDrain();

        $display("[TB] reset while waiting");
        mem_auto = 1'b0;
        applyStimulus(1'b0, 32'h8000_0080, 1'b0, 32'h0, 8'h0, 1'b0, acc);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        checkOutput("mid reset mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
        checkOutput("mid reset mem_addr", 64'(bus.mem_addr), 64'(0));
        checkOutput("mid reset rdata", 64'({bus.s1_rdata, bus.s0_rdata}), 64'(0));
        checkOutput("mid reset resp_valid", 64'({bus.s1_resp_valid, bus.s0_resp_valid}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.mem_rdata      = 32'h1234_5678;
        bus.mem_resp_valid = 1'b1;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'h0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.s0_resp_valid || bus.s1_resp_valid) seen = 1'b1;
            @(negedge clk);
        end
        checkOutput("stale resp delivered", 64'(seen), 64'(0));
        checkOutput("err after stale resp", 64'(err), 64'(1));

        mem_auto = 1'b1;
        applyStimulus(1'b1, 32'h8000_0200, 1'b0, 32'h0, 8'h0, 1'b1, acc);
        waitDrain();
        checkOutput("err sticky", 64'(err), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
